// File: rtl/go_cursor_ctrl.sv
// go_cursor_ctrl: Go move-entry controller; cursor seeks empty cells and offers moves via valid/ack
module go_cursor_ctrl #(
  parameter int BOARD_N    = 9,
  parameter int COORD_W    = 4,
  parameter int WRAP       = 0,
  parameter int REPEAT_CYC = 25_000_000
) (
  input  logic                                     clk_in,
  input  logic                                     reset_n,
  input  logic                                     my_turn,
  input  logic                                     up,
  input  logic                                     down,
  input  logic                                     left,
  input  logic                                     right,
  input  logic                                     place,
  input  logic                                     pass_sw,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0]     board,
  input  logic                                     move_ack,
  output logic                                     move_valid,
  output logic [2*COORD_W-1:0]                     move_out,
  output logic [2*COORD_W-1:0]                     cursor,
  output logic                                     illegal,
  output logic [2:0]                               state_dbg
);
  localparam int CW = $clog2(REPEAT_CYC + 1);
  localparam logic [COORD_W-1:0] LAST = COORD_W'(BOARD_N - 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(REPEAT_CYC - 1);
  typedef enum logic [2:0] {LOCKED, IDLE, SEEK, OFFER} state_t;
  state_t state_q;
  logic [3:0] dir_prev_q;
  logic place_prev_q, pass_prev_q, move_valid_q, illegal_q;
  logic [1:0] dir_q;
  logic [COORD_W-1:0] prow_q, pcol_q, crow_q, ccol_q, steps_q;
  logic [2*COORD_W-1:0] move_out_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] dirs, dir_pr;
  logic [1:0] dir_sel;
  logic held, rep, dir_go, at_edge, np_empty;
  logic [COORD_W-1:0] nrow_d, ncol_d;
  always_comb begin
    dirs = {right, left, down, up};
    dir_pr = dirs & ~dir_prev_q;
    dir_sel = dir_pr[0] ? 2'd0 : dir_pr[1] ? 2'd1 : dir_pr[2] ? 2'd2 : 2'd3;
    held = dirs == (4'b1 << dir_q);
    rep = state_q == IDLE && held && cnt_q == CNT_MAX;
    dir_go = |dir_pr || rep;
    at_edge = dir_q == 2'd0 ? prow_q == '0 : dir_q == 2'd1 ? prow_q == LAST :
              dir_q == 2'd2 ? pcol_q == '0 : pcol_q == LAST;
    // at an edge the step jumps to the opposite side; without WRAP the seek ends before using it
    nrow_d = dir_q == 2'd0 ? (at_edge ? LAST : prow_q - ONE) :
             dir_q == 2'd1 ? (at_edge ? '0 : prow_q + ONE) : prow_q;
    ncol_d = dir_q == 2'd2 ? (at_edge ? LAST : pcol_q - ONE) :
             dir_q == 2'd3 ? (at_edge ? '0 : pcol_q + ONE) : pcol_q;
    np_empty = board[nrow_d][ncol_d] == 2'b00;
    cnt_d = (state_q == IDLE && |dir_pr) || !held || !(state_q inside {IDLE, SEEK}) ? '0 :
            rep ? '0 : cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1);
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q <= LOCKED;
      dir_prev_q <= '0;
      place_prev_q <= 1'b0;
      pass_prev_q <= 1'b0;
      move_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      dir_q <= '0;
      prow_q <= '0;
      pcol_q <= '0;
      crow_q <= '0;
      ccol_q <= '0;
      steps_q <= '0;
      move_out_q <= '0;
      cnt_q <= '0;
    end else begin
      dir_prev_q <= dirs;
      place_prev_q <= place;
      pass_prev_q <= pass_sw;
      cnt_q <= cnt_d;
      illegal_q <= 1'b0;
      if (state_q != LOCKED && !my_turn) begin
        state_q <= LOCKED;
        move_valid_q <= 1'b0;
      end else begin
        case (state_q)
          LOCKED: if (my_turn) state_q <= IDLE;
          IDLE: begin
            if (pass_sw && !pass_prev_q) begin
              move_out_q <= '1;
              move_valid_q <= 1'b1;
              state_q <= OFFER;
            end else if (place && !place_prev_q) begin
              if (board[crow_q][ccol_q] == 2'b00) begin
                move_out_q <= {crow_q, ccol_q};
                move_valid_q <= 1'b1;
                state_q <= OFFER;
              end else illegal_q <= 1'b1;
            end else if (dir_go) begin
              dir_q <= |dir_pr ? dir_sel : dir_q;
              prow_q <= crow_q;
              pcol_q <= ccol_q;
              steps_q <= '0;
              state_q <= SEEK;
            end
          end
          SEEK: begin
            if (at_edge && WRAP == 0) state_q <= IDLE;
            else if (np_empty) begin
              crow_q <= nrow_d;
              ccol_q <= ncol_d;
              state_q <= IDLE;
            end else if (steps_q == LAST - ONE) state_q <= IDLE;
            else begin
              prow_q <= nrow_d;
              pcol_q <= ncol_d;
              steps_q <= steps_q + ONE;
            end
          end
          OFFER: if (move_ack) begin
            move_valid_q <= 1'b0;
            state_q <= LOCKED;
          end
          default: state_q <= LOCKED;
        endcase
      end
    end
  end
  assign move_valid = move_valid_q;
  assign move_out = move_out_q;
  assign cursor = {crow_q, ccol_q};
  assign illegal = illegal_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_go_cursor_ctrl.sv
// tb_go_cursor_ctrl: directed and randomized checks of two controllers (no wrap / wrap) on a 9x9 board
module tb_go_cursor_ctrl;
  localparam int N = 9;
  logic clk = 1'b0;
  logic rst_n, my_turn, up, down, left, right, place, pass_sw, move_ack;
  logic [N-1:0][N-1:0][1:0] board;
  logic mv [2];
  logic ill [2];
  logic [7:0] mo [2];
  logic [7:0] cur [2];
  logic [2:0] st [2];
  logic [7:0] mc [2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  go_cursor_ctrl #(.BOARD_N(N), .COORD_W(4), .WRAP(0), .REPEAT_CYC(4)) u0 (
    .clk_in(clk), .reset_n(rst_n), .my_turn(my_turn), .up(up), .down(down), .left(left),
    .right(right), .place(place), .pass_sw(pass_sw), .board(board), .move_ack(move_ack),
    .move_valid(mv[0]), .move_out(mo[0]), .cursor(cur[0]), .illegal(ill[0]), .state_dbg(st[0]));
  go_cursor_ctrl #(.BOARD_N(N), .COORD_W(4), .WRAP(1), .REPEAT_CYC(4)) u1 (
    .clk_in(clk), .reset_n(rst_n), .my_turn(my_turn), .up(up), .down(down), .left(left),
    .right(right), .place(place), .pass_sw(pass_sw), .board(board), .move_ack(move_ack),
    .move_valid(mv[1]), .move_out(mo[1]), .cursor(cur[1]), .illegal(ill[1]), .state_dbg(st[1]));
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] seek_model(input logic [7:0] c, input int d, input bit wrap);
    int r0 = int'(c[7:4]);
    int c0 = int'(c[3:0]);
    int dr = d == 0 ? -1 : d == 1 ? 1 : 0;
    int dc = d == 2 ? -1 : d == 3 ? 1 : 0;
    int r, cl;
    for (int k = 1; k < N; k++) begin
      r = r0 + k * dr;
      cl = c0 + k * dc;
      if (wrap) begin
        r = (r + N) % N;
        cl = (cl + N) % N;
      end else if (r < 0 || r >= N || cl < 0 || cl >= N) return c;
      if (board[r][cl] == 2'b00) return {4'(r), 4'(cl)};
    end
    return c;
  endfunction
  task automatic set_dir(input int d, input logic v);
    if (d == 0) up = v;
    else if (d == 1) down = v;
    else if (d == 2) left = v;
    else right = v;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20 && !(st[0] == 3'd1 && st[1] == 3'd1); i++) tick(1);
    chk("seek_done", {st[0], st[1]}, {3'd1, 3'd1});
  endtask
  task automatic do_move(input int d);
    set_dir(d, 1'b1);
    tick(1);
    set_dir(d, 1'b0);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      mc[i] = seek_model(mc[i], d, i == 1);
      chk($sformatf("cursor_u%0d", i), cur[i], mc[i]);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    my_turn = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    mc[0] = 8'h00;
    mc[1] = 8'h00;
    chk("reenter_idle", {st[0], st[1]}, {3'd1, 3'd1});
  endtask
  task automatic pulse_place();
    place = 1'b1;
    tick(1);
    place = 1'b0;
  endtask
  task automatic ack_and_reenter();
    move_ack = 1'b1;
    tick(1);
    move_ack = 1'b0;
    my_turn = 1'b0;
    tick(1);
    my_turn = 1'b1;
    tick(1);
    chk("back_idle", {st[0], st[1]}, {3'd1, 3'd1});
  endtask
  initial begin
    rst_n = 1'b0; my_turn = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    place = 1'b0; pass_sw = 1'b0; move_ack = 1'b0; board = '0;
    mc[0] = 8'h00; mc[1] = 8'h00;
    tick(2);
    chk("rst_cursor", cur[0], 8'h00);
    chk("rst_valid", mv[0], 1'b0);
    chk("rst_move_out", mo[0], 8'h00);
    chk("rst_illegal", ill[0], 1'b0);
    chk("rst_state", st[0], 3'd0);
    do_reset();
    // walk right then past the left edge: no-wrap clamps, wrap lands on column 8
    for (int i = 0; i < 3; i++) do_move(3);
    chk("right3", cur[0], 8'h03);
    for (int i = 0; i < 4; i++) do_move(2);
    chk("left4_nowrap", cur[0], 8'h00);
    chk("left4_wrap", cur[1], 8'h08);
    do_reset();
    board[0][1] = 2'b01;
    board[0][2] = 2'b10;
    right = 1'b1;
    tick(1);
    right = 1'b0;
    tick(2);
    chk("seek_busy", st[0], 3'd2);
    tick(1);
    chk("seek_lat_state", st[0], 3'd1);
    chk("seek_skip", cur[0], 8'h03);
    do_reset();
    for (int c = 1; c < N; c++) board[0][c] = 2'b01;
    do_move(3);
    chk("row_full_nowrap", cur[0], 8'h00);
    chk("row_full_wrap", cur[1], 8'h00);
    do_reset();
    board = '0;
    for (int i = 0; i < 4; i++) do_move(1);
    for (int i = 0; i < 8; i++) do_move(3);
    board[4][0] = 2'b01;
    board[4][1] = 2'b10;
    do_move(3);
    chk("wrap_right", cur[1], 8'h42);
    chk("edge_right", cur[0], 8'h48);
    do_reset();
    board = '0;
    for (int i = 0; i < 2; i++) do_move(1);
    for (int i = 0; i < 3; i++) do_move(3);
    pulse_place();
    for (int i = 0; i < 5; i++) begin
      chk("offer_valid", mv[0], 1'b1);
      chk("offer_move", mo[0], 8'h23);
      chk("offer_state", st[0], 3'd3);
      tick(1);
    end
    move_ack = 1'b1;
    tick(1);
    move_ack = 1'b0;
    my_turn = 1'b0;
    chk("ack_valid", mv[0], 1'b0);
    chk("ack_state", st[0], 3'd0);
    right = 1'b1;
    tick(1);
    right = 1'b0;
    tick(3);
    chk("locked_state", st[0], 3'd0);
    chk("locked_cursor", cur[0], 8'h23);
    my_turn = 1'b1;
    tick(1);
    chk("turn_idle", st[0], 3'd1);
    board[2][3] = 2'b01;
    pulse_place();
    chk("illegal_pulse", ill[0], 1'b1);
    chk("illegal_no_valid", mv[0], 1'b0);
    tick(1);
    chk("illegal_one_cycle", ill[0], 1'b0);
    pass_sw = 1'b1;
    tick(1);
    pass_sw = 1'b0;
    chk("pass_valid", mv[0], 1'b1);
    chk("pass_move", mo[0], 8'hFF);
    ack_and_reenter();
    do_reset();
    board = '0;
    down = 1'b1;
    tick(14);
    down = 1'b0;
    wait_idle();
    chk("repeat_nowrap", cur[0], 8'h40);
    chk("repeat_wrap", cur[1], 8'h40);
    pass_sw = 1'b1;
    tick(1);
    pass_sw = 1'b0;
    chk("offer2_valid", mv[0], 1'b1);
    my_turn = 1'b0;
    move_ack = 1'b1;
    tick(1);
    move_ack = 1'b0;
    chk("abort_valid", mv[0], 1'b0);
    chk("abort_state", st[0], 3'd0);
    // random boards and moves against the reference model, occasional placement
    do_reset();
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          board[r][c] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_move(int'($urandom_range(0, 3)));
      if (it % 6 == 5) begin
        pulse_place();
        for (int i = 0; i < 2; i++) begin
          if (board[mc[i][7:4]][mc[i][3:0]] == 2'b00) begin
            chk($sformatf("rnd_valid_u%0d", i), mv[i], 1'b1);
            chk($sformatf("rnd_move_u%0d", i), mo[i], mc[i]);
          end else begin
            chk($sformatf("rnd_illegal_u%0d", i), ill[i], 1'b1);
            chk($sformatf("rnd_novalid_u%0d", i), mv[i], 1'b0);
          end
        end
        ack_and_reenter();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/go_cursor_ctrl.md
Name: go_cursor_ctrl

Overview:
- Parametrised player move-entry controller for the Go board.
- Converts level-sensitive, already-debounced direction, place and pass buttons into a cursor that steps to the next empty intersection.
- Offers the finished move to the game engine through a valid/ack handshake.
- Generalises the single-size cursor logic: any board size, optional wrap-around, auto-repeat on held buttons, illegal-placement flag, pass handshake.

Parameters:
- BOARD_N, 9, board side length (2..15).
- COORD_W, 4, bits per coordinate; must satisfy BOARD_N-1 < 2**COORD_W - 1.
- WRAP, 0, 1 = seek wraps past an edge to the opposite edge of the same row/column.
- REPEAT_CYC, 25_000_000, cycles a direction must be held before each auto-repeat step.

Ports:
- clk_in  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- my_turn  input  1  high while the engine awaits this player's move
- up, down, left, right  input  1 each  debounced direction levels
- place  input  1  debounced place level
- pass_sw  input  1  debounced pass level
- board  input  2 x [BOARD_N][BOARD_N]  cell state; 2'b00 = empty
- move_ack  input  1  engine accepts the offered move
- move_valid  output  1  move offered
- move_out  output  2*COORD_W  {row,col}; all ones = pass
- cursor  output  2*COORD_W  {row,col} current cursor
- illegal  output  1  one-cycle pulse when place is pressed on an occupied cell
- state_dbg  output  3  current state encoding

Behaviour:
- Reset (reset_n low at a clk_in edge):
  - cursor = {0,0}, move_valid = 0, move_out = 0, illegal = 0.
  - State = LOCKED; repeat counter = 0; edge-detect registers cleared.
- Rising-edge detection on up/down/left/right/place/pass_sw; a press = 0->1 transition.
- Direction priority when several are pressed in the same cycle: up > down > left > right.
- Auto-repeat:
  - While exactly the latched direction stays high in IDLE, the counter increments.
  - On reaching REPEAT_CYC-1 it generates a synthetic press and clears.
  - Releasing the direction clears the counter.
- States:
  - LOCKED:
    - All button presses are ignored.
    - Goes to IDLE on the cycle after my_turn is seen high.
  - IDLE:
    - Priority: pass press > place press > direction press.
    - Pass press -> move_out = all ones, go to OFFER.
    - Place press on an empty cursor cell -> move_out = cursor, go to OFFER.
    - Place press on an occupied cell -> illegal = 1 for exactly one cycle; stay in IDLE.
    - Direction press -> latch dir, probe = cursor, go to SEEK.
  - SEEK:
    - Advances probe one cell per cycle in dir.
    - Probe lands on an empty cell -> cursor = probe, go to IDLE.
    - Next step would leave the board:
      - WRAP = 0: cursor unchanged, go to IDLE.
      - WRAP = 1: probe jumps to the opposite edge and the search continues.
    - WRAP = 1 stops after BOARD_N-1 steps with no empty cell found; cursor unchanged, go to IDLE.
    - Worst-case latency is BOARD_N-1 cycles.
    - Coordinate arithmetic is COORD_W-bit unsigned; edge tests are against 0 and BOARD_N-1, never against overflow.
  - OFFER:
    - move_valid = 1; move_out is held stable.
    - Cycle with move_valid & move_ack -> move_valid = 0 next cycle, go to LOCKED.
    - move_ack while move_valid = 0 is ignored.
- my_turn low in any state other than LOCKED:
  - Abort to LOCKED next cycle; move_valid drops to 0.
  - An in-progress SEEK is discarded and the cursor keeps its pre-seek value.
  - my_turn low takes precedence over move_ack arriving in the same cycle.
- The cursor persists across turns. It is not revalidated on turn entry; a place press on an occupied cell only raises illegal.
- board is sampled combinationally each cycle; changes during SEEK apply to the remaining probes.
- Reset asserted mid-operation returns to the reset state regardless of the handshake.

Test Plan:
1. Empty 9x9 board, reset, my_turn = 1; press right 3 times (gaps between presses) -> cursor = {0,3}. Then press left 4 times -> cursor = {0,0}, no wrap with WRAP = 0.
2. Cells (0,1) and (0,2) occupied, cursor {0,0}, press right -> cursor = {0,3} after 3 SEEK cycles. With (0,1)..(0,8) all occupied -> cursor stays {0,0}.
3. WRAP = 1, cursor {4,8}, cells (4,0) and (4,1) occupied, press right -> cursor = {4,2}.
4. Cursor {2,3} empty, press place -> move_valid = 1, move_out = 8'h23, held 5 cycles. Assert move_ack -> move_valid = 0 next cycle, state LOCKED; further presses ignored until my_turn re-enters.
5. Cursor on occupied cell, press place -> illegal pulses exactly 1 cycle, move_valid stays 0. Press pass -> move_out = 8'hFF, move_valid = 1.
6. Set REPEAT_CYC = 4 for the bench; hold down for 14 cycles on an empty board -> cursor row advances 1 (press) + 3 (repeats). Drop my_turn during OFFER -> move_valid = 0 next cycle.
